// File: rtl/fma_pkg.sv
// Shared encodings, biases and lane geometry for the FMA exponent
// alignment scheduler and its shift/swap calculator.
package fma_pkg;

    typedef enum logic [1:0] {
        PRE_4L  = 2'b00,
        PRE_2L  = 2'b01,
        PRE_1L  = 2'b10,
        PRE_4LA = 2'b11
    } pre_e;

    localparam int unsigned EXP_W  = 20;
    localparam int unsigned SWAP_W = 4;
    localparam int unsigned TAG_W  = 4;

    localparam int unsigned LANE_W_4L = 5;
    localparam int unsigned LANE_W_2L = 10;
    localparam int unsigned LANE_W_1L = 20;
    localparam int unsigned OPND_W_2L = 8;
    localparam int unsigned OPND_W_1L = 16;

    localparam logic [LANE_W_4L-1:0] BIAS_4L = 5'd16;
    localparam logic [LANE_W_2L-1:0] BIAS_2L = 10'd30;
    localparam logic [LANE_W_1L-1:0] BIAS_1L = 20'd58;

    typedef struct packed {
        logic [EXP_W-1:0] e;
        logic [EXP_W-1:0] f;
        pre_e             pre;
        logic [TAG_W-1:0] tag;
        logic             src;
    } s1_t;

endpackage

// File: rtl/align_shift_calc.sv
// Combinational exponent-difference to alignment-shift/swap mapping
// for 4x5b, 2x10b and 1x20b lane configurations.
module align_shift_calc
    import fma_pkg::*;
(
    input  logic [EXP_W-1:0]  e,
    input  logic [EXP_W-1:0]  f,
    input  pre_e              pre,
    output logic [EXP_W-1:0]  ctl,
    output logic [SWAP_W-1:0] swap
);

    logic [LANE_W_4L-1:0] d5;
    logic [LANE_W_2L-1:0] d10;
    logic [LANE_W_1L-1:0] d20;

    always_comb begin
        ctl  = '0;
        swap = '0;
        d5   = '0;
        d10  = '0;
        d20  = '0;
        unique case (pre)
            PRE_2L: begin
                for (int j = 0; j < 2; j++) begin
                    d10 = {{(LANE_W_2L-OPND_W_2L){1'b0}},
                           e[j*OPND_W_2L +: OPND_W_2L]}
                        - {{(LANE_W_2L-OPND_W_2L){1'b0}},
                           f[j*OPND_W_2L +: OPND_W_2L]};
                    if (d10[LANE_W_2L-1]) begin
                        swap[2*j+1] = 1'b1;
                        ctl[j*LANE_W_2L +: LANE_W_2L] = BIAS_2L + d10;
                    end else begin
                        ctl[j*LANE_W_2L +: LANE_W_2L] = BIAS_2L - d10;
                    end
                end
            end
            PRE_1L: begin
                d20 = {{(LANE_W_1L-OPND_W_1L){1'b0}}, e[OPND_W_1L-1:0]}
                    - {{(LANE_W_1L-OPND_W_1L){1'b0}}, f[OPND_W_1L-1:0]};
                if (d20[LANE_W_1L-1]) begin
                    swap[3] = 1'b1;
                    ctl     = BIAS_1L + d20;
                end else begin
                    ctl     = BIAS_1L - d20;
                end
            end
            PRE_4L, PRE_4LA: begin
                for (int i = 0; i < 4; i++) begin
                    d5 = e[i*LANE_W_4L +: LANE_W_4L]
                       - f[i*LANE_W_4L +: LANE_W_4L];
                    if (d5[LANE_W_4L-1]) begin
                        swap[i] = 1'b1;
                        ctl[i*LANE_W_4L +: LANE_W_4L] = BIAS_4L + d5;
                    end else begin
                        ctl[i*LANE_W_4L +: LANE_W_4L] = BIAS_4L - d5;
                    end
                end
            end
        endcase
    end

endmodule

// File: rtl/fma_align_sched.sv
// Two-requester round-robin front end feeding a 2-stage align pipeline.
// Define FMA_ALIGN_SCHED_STATS_EN to add saturating per-requester grant counters.
module fma_align_sched
    import fma_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              rq0_valid,
    output logic              rq0_ready,
    input  logic [EXP_W-1:0]  rq0_exp_e,
    input  logic [EXP_W-1:0]  rq0_exp_f,
    input  logic [1:0]        rq0_pre,
    input  logic [TAG_W-1:0]  rq0_tag,
    input  logic              rq1_valid,
    output logic              rq1_ready,
    input  logic [EXP_W-1:0]  rq1_exp_e,
    input  logic [EXP_W-1:0]  rq1_exp_f,
    input  logic [1:0]        rq1_pre,
    input  logic [TAG_W-1:0]  rq1_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [EXP_W-1:0]  out_ctl,
    output logic [SWAP_W-1:0] out_swap,
    output logic [1:0]        out_pre,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_src
`ifdef FMA_ALIGN_SCHED_STATS_EN
    ,
    output logic [15:0]       gnt_cnt0,
    output logic [15:0]       gnt_cnt1
`endif
);

    logic              last_grant;
    logic              s1_valid;
    s1_t               s1_q;
    s1_t               s1_d;
    logic              s2_adv;
    logic              s1_open;
    logic              gnt0;
    logic              gnt1;
    logic [EXP_W-1:0]  c_ctl;
    logic [SWAP_W-1:0] c_swap;

    assign s2_adv  = !out_valid || out_ready;
    assign s1_open = !s1_valid || s2_adv;

    // last_grant==1 means rq1 went last, so rq0 wins a tie
    assign gnt0 = rq0_valid && (!rq1_valid || last_grant);
    assign gnt1 = rq1_valid && (!rq0_valid || !last_grant);

    assign rq0_ready = gnt0 && s1_open && !rst;
    assign rq1_ready = gnt1 && s1_open && !rst;

    always_comb begin
        s1_d = '0;
        if (rq1_ready) begin
            s1_d.e   = rq1_exp_e;
            s1_d.f   = rq1_exp_f;
            s1_d.pre = pre_e'(rq1_pre);
            s1_d.tag = rq1_tag;
            s1_d.src = 1'b1;
        end else begin
            s1_d.e   = rq0_exp_e;
            s1_d.f   = rq0_exp_f;
            s1_d.pre = pre_e'(rq0_pre);
            s1_d.tag = rq0_tag;
            s1_d.src = 1'b0;
        end
    end

    align_shift_calc u_calc (
        .e    (s1_q.e),
        .f    (s1_q.f),
        .pre  (s1_q.pre),
        .ctl  (c_ctl),
        .swap (c_swap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            s1_valid   <= 1'b0;
            s1_q       <= '0;
            out_valid  <= 1'b0;
            out_ctl    <= '0;
            out_swap   <= '0;
            out_pre    <= '0;
            out_tag    <= '0;
            out_src    <= 1'b0;
        end else begin
            if (rq0_ready) begin
                last_grant <= 1'b0;
            end else if (rq1_ready) begin
                last_grant <= 1'b1;
            end
            if (s1_open) begin
                s1_valid <= rq0_ready || rq1_ready;
                if (rq0_ready || rq1_ready) begin
                    s1_q <= s1_d;
                end
            end
            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_ctl  <= c_ctl;
                    out_swap <= c_swap;
                    out_pre  <= s1_q.pre;
                    out_tag  <= s1_q.tag;
                    out_src  <= s1_q.src;
                end
            end
        end
    end

`ifdef FMA_ALIGN_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
        end else begin
            if (rq0_ready && gnt_cnt0 != 16'hFFFF) begin
                gnt_cnt0 <= gnt_cnt0 + 16'd1;
            end
            if (rq1_ready && gnt_cnt1 != 16'hFFFF) begin
                gnt_cnt1 <= gnt_cnt1 + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fma_align_sched.sv
// Directed bench for fma_align_sched: lane math, arbitration,
// backpressure and mid-flight reset.
module tb_fma_align_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        rq0_valid, rq0_ready;
    logic [19:0] rq0_exp_e, rq0_exp_f;
    logic [1:0]  rq0_pre;
    logic [3:0]  rq0_tag;
    logic        rq1_valid, rq1_ready;
    logic [19:0] rq1_exp_e, rq1_exp_f;
    logic [1:0]  rq1_pre;
    logic [3:0]  rq1_tag;
    logic        out_valid, out_ready;
    logic [19:0] out_ctl;
    logic [3:0]  out_swap;
    logic [1:0]  out_pre;
    logic [3:0]  out_tag;
    logic        out_src;
`ifdef FMA_ALIGN_SCHED_STATS_EN
    logic [15:0] gnt_cnt0, gnt_cnt1;
`endif

    int tests = 0;
    int fails = 0;
    int acc;

    always #5 clk = ~clk;

    fma_align_sched dut (
        .clk       (clk),
        .rst       (rst),
        .rq0_valid (rq0_valid),
        .rq0_ready (rq0_ready),
        .rq0_exp_e (rq0_exp_e),
        .rq0_exp_f (rq0_exp_f),
        .rq0_pre   (rq0_pre),
        .rq0_tag   (rq0_tag),
        .rq1_valid (rq1_valid),
        .rq1_ready (rq1_ready),
        .rq1_exp_e (rq1_exp_e),
        .rq1_exp_f (rq1_exp_f),
        .rq1_pre   (rq1_pre),
        .rq1_tag   (rq1_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctl   (out_ctl),
        .out_swap  (out_swap),
        .out_pre   (out_pre),
        .out_tag   (out_tag),
        .out_src   (out_src)
`ifdef FMA_ALIGN_SCHED_STATS_EN
        ,
        .gnt_cnt0  (gnt_cnt0),
        .gnt_cnt1  (gnt_cnt1)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rq0_valid = 1'b0;
        rq1_valid = 1'b0;
    endtask

    task automatic drv(input logic which, input logic [19:0] e,
                       input logic [19:0] f, input logic [1:0] pre,
                       input logic [3:0] tag);
        if (which) begin
            rq1_exp_e = e; rq1_exp_f = f;
            rq1_pre = pre; rq1_tag = tag;
            rq1_valid = 1'b1;
        end else begin
            rq0_exp_e = e; rq0_exp_f = f;
            rq0_pre = pre; rq0_tag = tag;
            rq0_valid = 1'b1;
        end
    endtask

    task automatic rdy(input string tag, input logic [1:0] exp);
        chk(tag, 32'({rq1_ready, rq0_ready}), 32'(exp));
    endtask

    task automatic chk_out(input string tag, input logic [19:0] ctl,
                           input logic [3:0] swap, input logic [1:0] pre,
                           input logic [3:0] otag, input logic src);
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".ctl"},   32'(out_ctl),   32'(ctl));
        chk({tag, ".swap"},  32'(out_swap),  32'(swap));
        chk({tag, ".pre"},   32'(out_pre),   32'(pre));
        chk({tag, ".tag"},   32'(out_tag),   32'(otag));
        chk({tag, ".src"},   32'(out_src),   32'(src));
    endtask

    // Issue one lone request; returns with its result on the outputs.
    task automatic single(input string tag, input logic which,
                          input logic [19:0] e, input logic [19:0] f,
                          input logic [1:0] pre, input logic [3:0] otag);
        drv(which, e, f, pre, otag);
        #1;
        rdy({tag, ".rdy"}, which ? 2'b10 : 2'b01);
        tick();
        idle();
        #1;
        chk({tag, ".lat1"}, 32'(out_valid), 32'd0);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b1;
        idle();
        drv(1'b0, 20'd5, 20'd3, 2'b00, 4'h1);
        rq1_exp_e = '0; rq1_exp_f = '0; rq1_pre = '0; rq1_tag = '0;
        tick();
        tick();
        #1;
        rdy("rst.rdy", 2'b00);
        chk("rst.valid", 32'(out_valid), 32'd0);
        chk("rst.ctl",   32'(out_ctl),   32'd0);
        chk("rst.swap",  32'(out_swap),  32'd0);
        chk("rst.pre",   32'(out_pre),   32'd0);
        chk("rst.tag",   32'(out_tag),   32'd0);
        chk("rst.src",   32'(out_src),   32'd0);
        rst = 1'b0;
        idle();
        tick();
        chk("rst.noacc1", 32'(out_valid), 32'd0);
        tick();
        chk("rst.noacc2", 32'(out_valid), 32'd0);

        single("m00a", 1'b0, 20'd5, 20'd3, 2'b00, 4'hA);
        chk_out("m00a", 20'h8420E, 4'b0000, 2'b00, 4'hA, 1'b0);
        tick();
        chk("m00a.drain", 32'(out_valid), 32'd0);

        single("m00b", 1'b1, 20'd3, 20'd5, 2'b00, 4'hB);
        chk_out("m00b", 20'h8420E, 4'b0001, 2'b00, 4'hB, 1'b1);
        tick();

        single("m11", 1'b0, 20'd5, 20'd3, 2'b11, 4'hC);
        chk_out("m11", 20'h8420E, 4'b0000, 2'b11, 4'hC, 1'b0);
        tick();

        single("m00c", 1'b1, 20'hF8147, 20'h07C87, 2'b00, 4'h4);
        chk_out("m00c", 20'h7BD50, 4'b1000, 2'b00, 4'h4, 1'b1);
        tick();

        single("m01a", 1'b0, 20'd40, 20'd10, 2'b01, 4'h5);
        chk_out("m01a", 20'h07800, 4'b0000, 2'b01, 4'h5, 1'b0);
        tick();

        single("m01b", 1'b0, 20'd10, 20'd40, 2'b01, 4'h6);
        chk_out("m01b", 20'h07800, 4'b0010, 2'b01, 4'h6, 1'b0);
        tick();

        single("m10a", 1'b0, 20'd50, 20'd20, 2'b10, 4'h7);
        chk_out("m10a", 20'h0001C, 4'b0000, 2'b10, 4'h7, 1'b0);
        tick();

        single("m10b", 1'b0, 20'd20, 20'd50, 2'b10, 4'h8);
        chk_out("m10b", 20'h0001C, 4'b1000, 2'b10, 4'h8, 1'b0);
        tick();

        single("m10c", 1'b1, 20'hF0032, 20'h00014, 2'b10, 4'h9);
        chk_out("m10c", 20'h0001C, 4'b0000, 2'b10, 4'h9, 1'b1);
        tick();

        // Round robin, both requesters streaming
        for (int c = 0; c < 6; c++) begin
            if (c < 4) begin
                drv(1'b0, 20'd5, 20'd3, 2'b00, 4'h3);
                drv(1'b1, 20'd3, 20'd5, 2'b00, 4'h9);
            end else begin
                idle();
            end
            #1;
            if (c < 4) rdy($sformatf("rr.rdy%0d", c), (c % 2 == 0) ? 2'b01 : 2'b10);
            if (c >= 2) begin
                chk($sformatf("rr.valid%0d", c), 32'(out_valid), 32'd1);
                chk($sformatf("rr.src%0d", c), 32'(out_src), 32'(c % 2));
                chk($sformatf("rr.tag%0d", c), 32'(out_tag),
                    (c % 2 == 0) ? 32'h3 : 32'h9);
            end
            tick();
        end
        chk("rr.end", 32'(out_valid), 32'd0);

        // Backpressure with both requesters valid
        acc = 0;
        out_ready = 1'b0;
        drv(1'b0, 20'd5, 20'd3, 2'b00, 4'h3);
        drv(1'b1, 20'd3, 20'd5, 2'b00, 4'h9);
        for (int c = 0; c < 5; c++) begin
            #1;
            acc += int'(rq0_valid && rq0_ready) + int'(rq1_valid && rq1_ready);
            rdy($sformatf("bp.rdy%0d", c),
                (c == 0) ? 2'b01 : (c == 1) ? 2'b10 : 2'b00);
            if (c >= 2) begin
                chk($sformatf("bp.valid%0d", c), 32'(out_valid), 32'd1);
                chk($sformatf("bp.tag%0d", c), 32'(out_tag), 32'h3);
                chk($sformatf("bp.ctl%0d", c), 32'(out_ctl), 32'h8420E);
                chk($sformatf("bp.swap%0d", c), 32'(out_swap), 32'd0);
            end
            tick();
        end
        chk("bp.acc", 32'(acc), 32'd2);
        idle();
        out_ready = 1'b1;
        #1;
        chk_out("bp.o0", 20'h8420E, 4'b0000, 2'b00, 4'h3, 1'b0);
        tick();
        chk_out("bp.o1", 20'h8420E, 4'b0001, 2'b00, 4'h9, 1'b1);
        tick();
        chk("bp.end", 32'(out_valid), 32'd0);

        // Reset with both stages occupied; fill rq1 first so rq1 would win a tie
        out_ready = 1'b0;
        drv(1'b1, 20'd3, 20'd5, 2'b00, 4'h9);
        #1;
        rdy("mr.fill1", 2'b10);
        tick();
        idle();
        drv(1'b0, 20'd5, 20'd3, 2'b00, 4'h3);
        #1;
        rdy("mr.fill0", 2'b01);
        tick();
        drv(1'b1, 20'd3, 20'd5, 2'b00, 4'h9);
        rst = 1'b1;
        #1;
        chk("mr.full", 32'(out_valid), 32'd1);
        rdy("mr.rstrdy", 2'b00);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("mr.cleared", 32'(out_valid), 32'd0);
        rdy("mr.first", 2'b01);
        tick();
        idle();
        #1;
        chk("mr.nostale", 32'(out_valid), 32'd0);
        tick();
        chk_out("mr.o", 20'h8420E, 4'b0000, 2'b00, 4'h3, 1'b0);
        tick();
        chk("mr.end", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fma_align_sched.md
FMA_ALIGN_SCHED -- requirements
Module: fma_align_sched

Interface
REQ-001 SHALL have port clk, input, 1: single rising-edge clock.
REQ-002 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-003 SHALL have ports rq0_valid / rq1_valid, input, 1 each: requester n has an operation pending.
REQ-004 SHALL have ports rq0_ready / rq1_ready, output, 1 each: requester n's operation is accepted this cycle.
REQ-005 SHALL have ports rqN_exp_e and rqN_exp_f, input, 20 each: packed exponent operands.
REQ-006 SHALL have ports rqN_pre, input, 2: precision mode (00 = 4x5b lanes, 01 = 2x10b lanes, 10 = 1x20b lane, 11 = same as 00).
REQ-007 SHALL have ports rqN_tag, input, 4: opaque ID, returned unchanged.
REQ-008 SHALL have ports out_valid (output, 1) and out_ready (input, 1): result handshake.
REQ-009 SHALL have port out_ctl, output, 20: alignment shift controls.
REQ-010 SHALL have port out_swap, output, 4: per-lane operand-swap flags.
REQ-011 SHALL have ports out_pre (output, 2), out_tag (output, 4) and out_src (output, 1): mode, tag and requester index of the result.

Function
REQ-012 SHALL transfer data on a port only when its valid and ready are both high in the same clock cycle.
REQ-013 SHALL arbitrate round-robin: when both requesters are valid, grant the one not granted last; last_grant resets to 1, so rq0 wins first.
REQ-014 SHALL assert at most one rqN_ready per cycle, and only when stage S1 is empty or advancing.
REQ-015 SHALL use a 2-stage pipeline: S1 registers the granted request; S2 registers the computed result.
REQ-016 SHALL give 2-cycle latency from acceptance to out_valid when out_ready stays high, sustaining 1 operation per cycle.
REQ-017 SHALL, when out_valid is high and out_ready is low, hold all out_* signals stable, hold S1, and deassert both rqN_ready once S1 is full.
REQ-018 SHALL compute mode 00 per 5-bit lane i as d = E_i - F_i mod 32; if d[4] is set then swap[i]=1 and ctl_i = 16 + d, else swap[i]=0 and ctl_i = 16 - d; both results are 5-bit wrapping.
REQ-019 SHALL compute mode 01 per 10-bit lane j (operands from E/F bits [8j+7:8j]) as d = zero-extended 8-bit difference, mod 1024; test d[9] with bias 30; swap[2j+1] is the flag and swap[2j]=0.
REQ-020 SHALL compute mode 10 as d = E[15:0] - F[15:0] mod 2^20; test d[19] with bias 58; swap[3] is the flag and swap[2:0]=0.
REQ-021 SHALL make mode 11 produce results identical to mode 00, with out_pre reporting 11.
REQ-022 SHALL NOT drop or duplicate a request when rqN_valid falls while not granted; such requests are simply not accepted.

Reset
REQ-023 SHALL, on rst, clear both stage valid bits, set out_valid=0, rqN_ready=0, out_ctl=0, out_swap=0, out_pre=0, out_tag=0, out_src=0 and last_grant=1.
REQ-024 SHALL, on rst asserted mid-operation, discard in-flight operations without emitting them, and accept no request during the rst cycle.

Configuration
REQ-025 SHALL, with FMA_ALIGN_SCHED_STATS_EN defined, provide outputs gnt_cnt0 and gnt_cnt1 (16 bits each), counting accepted requests per requester, saturating at 0xFFFF and cleared by rst.
REQ-026 SHALL, without FMA_ALIGN_SCHED_STATS_EN, omit these ports and counters entirely, leaving all other behaviour identical.

Structure
REQ-027 SHALL place the mode encodings (PRE_4L, PRE_2L, PRE_1L), the biases (16, 30, 58) and the lane widths in the shared package fma_pkg.
REQ-028 SHALL implement the combinational shift and swap computation as one sub-module, align_shift_calc, instanced between S1 and S2.

Verification
REQ-029 SHALL cover: mode 00, rq0 with E lane0=5, F lane0=3, all other lanes 0 -> after 2 cycles ctl[4:0]=14, swap=0000, out_src=0.
REQ-030 SHALL cover: mode 00, E lane0=3, F lane0=5 -> ctl[4:0]=14, swap[0]=1.
REQ-031 SHALL cover: mode 01, E[7:0]=40, F[7:0]=10, upper lane E=F=0 -> ctl[9:0]=0, swap=0000; mode 10, E=50, F=20 -> ctl=28, swap=0000.
REQ-032 SHALL cover: both requesters valid for 4 cycles with out_ready=1 -> grants alternate 0,1,0,1 and out_src follows the same order.
REQ-033 SHALL cover: out_ready held low for 5 cycles with both requesters valid -> exactly 2 accepted, outputs stable, no loss after release.
REQ-034 SHALL cover: rst asserted with both stages full -> next cycle out_valid=0, no stale result emitted, rq0 granted first after release.
